load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencing stage that sits directly upstream of the byte-addressable 64-bit data memory, between the execute stage and `Data_Mem`. Accepts one load or store request at a time, sized byte/half/word/double, and drives the memory's address, `mem_rw` and bidirectional `mem_data` bus. Loads are extracted and sign- or zero-extended. Sub-doubleword stores use read-modify-write, so bytes outside the stored size are preserved.

## Interface
- `MEM_SIZE`, 8192: memory size in bytes; legal access addresses are 0 .. `MEM_SIZE`-8.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = B, 1 = H, 2 = W, 3 = D.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 64: extended load data; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; set on range or alignment fault.
- `mem_addr` out 64: address to the data memory.
- `mem_rw` out 1: 1 = write; the memory commits on the falling edge of `clk`.
- `mem_data` inout 64: driven only in WRITE, otherwise high-Z.

## Operation
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE → LOAD on an accepted load.
- IDLE → WRITE on an accepted D store.
- IDLE → RMW_RD on an accepted B/H/W store.
- IDLE → RESP with `resp_err`=1 on a faulting request. No memory access is made for a faulting request.
- Fault conditions:
  - `req_addr` > `MEM_SIZE`-8.
  - `req_addr` not naturally aligned to `req_size`: H needs bit0=0, W needs [1:0]=0, D needs [2:0]=0.
- LOAD: drive `mem_addr`=addr. Capture `mem_data` at the next rising edge, extract the low 8/16/32/64 bits, extend per `req_unsigned`. → RESP.
- RMW_RD: same read. Merge the low N bytes of the latched wdata over the read doubleword; the upper bytes are kept. → WRITE.
- WRITE: `mem_rw`=1, drive `mem_addr` and the merged doubleword on `mem_data` for the whole cycle. → RESP.
- RESP: `resp_valid`=1 for one cycle. → IDLE. There is no response backpressure.
- The request fields are latched on acceptance; inputs may change afterwards.

## Timing
- Accept in cycle T. `resp_valid` is asserted in:
  - T+2 for a load or a D store;
  - T+3 for a B/H/W store;
  - T+1 for a fault.
- Back-to-back: the next request can be accepted in the cycle after RESP.
- `mem_rw` is combinational: `(state==WRITE) & ~rst`. An asserted `rst` therefore suppresses an in-flight falling-edge write.
- Reset values:
  - state IDLE;
  - `resp_valid`, `resp_err`, `resp_rdata`, `mem_addr` = 0;
  - `mem_rw`=0 and `mem_data` high-Z;
  - `req_ready`=1 from the first cycle after `rst` deasserts, and 0 while `rst` is high.
- Reset mid-operation: the transaction is dropped, no response is produced, and memory is not modified.
- Boundary: addr=`MEM_SIZE`-8 is legal; `MEM_SIZE`-7 faults.

## Configuration
- `LSU_WR_BYTESWAP_EN`.
  - Defined: the doubleword placed on `mem_data` in WRITE is byte-reversed. `Data_Mem` stores bus bits [63:56] at addr and returns addr in bits [7:0], so this makes a store followed by a load round-trip identically.
  - RMW read data is not swapped; only the final write bus is.
  - Undefined: the merged doubleword is driven unmodified.

## Structure
- `lsu_pkg` holds:
  - `lsu_size_e` (B/H/W/D);
  - `lsu_state_e`;
  - the constant `LSU_DW_BYTES`=8.
- Sub-module `lsu_align` (combinational) provides load extraction with extension and the store merge by size. The FSM, registers and tri-state driver stay in `load_store_unit`.

## Test plan
- Reset then idle: `req_ready`=1, `mem_rw`=0, `mem_data`=Z, `resp_valid`=0.
- SD 0x0123456789ABCDEF @0x10, then LD @0x10: resp_rdata=0x0123456789ABCDEF with EN defined. Response latency is 2 cycles for each.
- SB 0xFF @0x10 over the prior data, then LD @0x10: 0x0123456789ABCDFF. LB @0x10 → 0xFFFFFFFFFFFFFFFF; LBU → 0xFF. The SB responds at T+3.
- LH @0x11 → resp_err=1 at T+1 with no memory access. LD @`MEM_SIZE`-8 succeeds; LD @`MEM_SIZE`-7 → err.
- `rst` asserted during the WRITE cycle of an SD: memory is unchanged, no `resp_valid`, and the unit returns to IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for load_store_unit (size and FSM state enums, doubleword width, alignment mask)
package lsu_pkg;
  localparam int LSU_DW_BYTES = 8;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} lsu_state_e;
  function automatic logic [2:0] align_mask(lsu_size_e s);
    return 3'((4'd1 << s) - 4'd1);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational load extract/extend and store merge by size; ports size, uns, rd_dw, wdata in; ld_data, merged out
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        uns,
  input  logic [63:0] rd_dw,
  input  logic [63:0] wdata,
  output logic [63:0] ld_data,
  output logic [63:0] merged
);
  logic [63:0] mask;
  logic        sign;
  always_comb begin
    mask    = size == SZ_B ? 64'hff : size == SZ_H ? 64'hffff : size == SZ_W ? 64'hffff_ffff : '1;
    sign    = size == SZ_B ? rd_dw[7] : size == SZ_H ? rd_dw[15] : size == SZ_W ? rd_dw[31] : rd_dw[63];
    ld_data = (rd_dw & mask) | ({64{sign & ~uns}} & ~mask);
    merged  = (wdata & mask) | (rd_dw & ~mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store sequencer to Data_Mem; req_* in, resp_* out, mem_addr/mem_rw/mem_data (inout) to memory; LSU_WR_BYTESWAP_EN byte-reverses the write bus
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic        mem_rw,
  inout  wire  [63:0] mem_data
);
  lsu_state_e  state, state_n;
  lsu_size_e   size_q;
  logic        uns_q;
  logic [63:0] wdata_q, ld_data, merged, wr_bus;
  logic        accept, fault;
  assign accept = req_valid & req_ready;
  assign fault  = (req_addr > 64'(MEM_SIZE - LSU_DW_BYTES)) |
                  (|(req_addr[2:0] & align_mask(lsu_size_e'(req_size))));
  lsu_align u_align (
    .size   (size_q),
    .uns    (uns_q),
    .rd_dw  (mem_data),
    .wdata  (wdata_q),
    .ld_data(ld_data),
    .merged (merged)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        size_q     <= lsu_size_e'(req_size);
        uns_q      <= req_unsigned;
        wdata_q    <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= fault;
        if (!fault) mem_addr <= req_addr;
      end
      if (state == S_LOAD) resp_rdata <= ld_data;
      // the write data register is reused to hold the merged doubleword
      if (state == S_RMW_RD) wdata_q <= merged;
    end
  end
  always_comb begin
    state_n = state == S_IDLE   ? (!accept ? S_IDLE : fault ? S_RESP : !req_we ? S_LOAD :
                                   req_size == 2'd3 ? S_WRITE : S_RMW_RD) :
              state == S_LOAD   ? S_RESP :
              state == S_RMW_RD ? S_WRITE :
              state == S_WRITE  ? S_RESP : S_IDLE;
  end
  always_comb begin
    req_ready  = (state == S_IDLE) & ~rst;
    resp_valid = state == S_RESP;
    mem_rw     = (state == S_WRITE) & ~rst;
  end
`ifdef LSU_WR_BYTESWAP_EN
  assign wr_bus = {<<8{wdata_q}};
`else
  assign wr_bus = wdata_q;
`endif
  assign mem_data = state == S_WRITE ? wr_bus : 64'bz;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a byte-array Data_Mem model and a reference model
module tb_load_store_unit;
  logic        clk = 0, rst = 1, req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err, mem_rw;
  logic [63:0] resp_rdata, mem_addr, rd_bus;
  wire  [63:0] mem_data;
  logic [7:0]  mem     [0:8191];
  logic [7:0]  ref_mem [0:8191];
  typedef struct {logic [63:0] rdata; logic err; int due;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int compared = 0, mismatched = 0, cyc = 0, resp_cnt = 0;
`ifdef LSU_WR_BYTESWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_data(mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data_Mem: bus byte j reads from addr+j; writes put bus [63:56] at addr on the falling edge
  always_comb
    for (int i = 0; i < 8; i++) rd_bus[8*i +: 8] = mem[13'(mem_addr[12:0] + 13'(i))];
  assign mem_data = mem_rw ? 64'bz : rd_bus;
  always @(negedge clk)
    if (mem_rw) for (int i = 0; i < 8; i++) mem[13'(mem_addr[12:0] + 13'(i))] <= mem_data[8*(7-i) +: 8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: bytewise view of the memory; returns the expected response and latency
  function automatic exp_t model(bit we, logic [1:0] sz, bit uns, logic [63:0] a, logic [63:0] wd);
    exp_t e;
    int nb = 1 << sz;
    logic [63:0] v = 0;
    logic [7:0] dw [8];
    e.rdata = 0;
    e.err = (a > 64'd8184) || (a % nb != 0);
    e.due = 1;
    if (e.err) return e;
    for (int k = 0; k < 8; k++) dw[k] = ref_mem[int'(a) + k];
    if (!we) begin
      for (int k = 0; k < nb; k++) v |= 64'(dw[k]) << (8*k);
      if (!uns && nb < 8 && dw[nb-1][7]) v |= ~64'd0 << (8*nb);
      e.rdata = v;
      e.due = 2;
    end else begin
      for (int k = 0; k < nb; k++) dw[k] = wd[8*k +: 8];
      for (int k = 0; k < 8; k++) ref_mem[int'(a) + (SWAP ? k : 7 - k)] = dw[k];
      e.due = nb == 8 ? 2 : 3;
    end
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the request
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [63:0] a, input logic [63:0] wd);
    exp_t e;
    int n = 0;
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 0, 1);
    else begin
      e = model(we, sz, uns, a, wd);
      e.due += cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    req_we = 1'($urandom); req_size = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk)
    if (resp_valid) begin
      resp_cnt++;
      if (sb.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", 64'(resp_err), 64'(mon_e.err));
        chk("resp_latency", 64'(cyc), 64'(mon_e.due));
      end
    end

  initial begin
    int r, nb, snap, diffs;
    logic [63:0] a;
    for (int i = 0; i < 8192; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_mem_rw", 64'(mem_rw), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", 64'(resp_err), 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 1);
    chk("idle_mem_rw", 64'(mem_rw), 0);
    chk("idle_resp_valid", 64'(resp_valid), 0);
    @(posedge clk); #1;
    issue(1, 3, 0, 64'h10, 64'h0123456789ABCDEF);
    issue(0, 3, 0, 64'h10, 0);
    issue(1, 0, 0, 64'h10, 64'hFF);
    issue(0, 3, 0, 64'h10, 0);
    issue(0, 0, 0, 64'h10, 0);
    issue(0, 0, 1, 64'h10, 0);
    issue(0, 1, 0, 64'h11, 0);
    issue(1, 2, 0, 64'h12, 64'hDEADBEEF);
    issue(0, 3, 0, 64'd8184, 0);
    issue(0, 3, 0, 64'd8185, 0);
    issue(1, 1, 0, 64'd8190, 64'h1234);
    issue(1, 3, 0, 64'd8184, 64'hA5A5_5A5A_0F0F_F0F0);
    issue(0, 2, 0, 64'd8188, 0);
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      req_size = 2'($urandom);
      nb = 1 << req_size;
      a = r == 0 ? 64'(8176 + $urandom_range(0, 23)) : 64'($urandom_range(0, 127));
      if (r < 8) a = a & ~64'(nb - 1);
      issue(1'($urandom), req_size, 1'($urandom), a, {$urandom, $urandom});
    end
    drain();
    // reset during the WRITE cycle of a doubleword store
    snap = resp_cnt;
    req_valid = 1; req_we = 1; req_size = 3; req_unsigned = 0; req_addr = 64'h40; req_wdata = {$urandom, $urandom};
    @(negedge clk);
    chk("kill_accept_ready", 64'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("kill_mem_rw", 64'(mem_rw), 0);
    chk("kill_req_ready", 64'(req_ready), 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("kill_ready_after", 64'(req_ready), 1);
    repeat (4) @(negedge clk);
    chk("kill_no_resp", 64'(resp_cnt - snap), 0);
    for (int k = 0; k < 8; k++) chk("kill_mem_byte", 64'(mem[64 + k]), 64'(ref_mem[64 + k]));
    @(posedge clk); #1;
    issue(0, 3, 1, 64'h40, 0);
    issue(1, 2, 0, 64'h44, 64'h8765_4321);
    issue(0, 2, 0, 64'h44, 0);
    drain();
    diffs = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image_diffs", 64'(diffs), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
